// File: rtl/plru_array_if.sv
// Access/victim bus between a cache controller and its pseudo-LRU state array.
// No timing of its own: carries the update, victim lookup and sweep-clear signals.
// No backpressure: busy tells the controller that updates are being dropped.
interface plru_array_if #(
  parameter int s_index = 3,
  parameter int s_ways  = 2
);
  logic               clear;
  logic               busy;
  logic [s_index-1:0] rd_index;
  logic [s_ways-1:0]  victim;
  logic               upd_en;
  logic [s_index-1:0] upd_index;
  logic [s_ways-1:0]  upd_way;

  // Cache controller side: drives accesses and lookups, observes victim/busy.
  modport master (
    output clear, rd_index, upd_en, upd_index, upd_way,
    input  busy, victim
  );

  // State array side.
  modport slave (
    input  clear, rd_index, upd_en, upd_index, upd_way,
    output busy, victim
  );
endinterface

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state (num_ways-1 bits/set) with sweep clear; optional macro PLRU_BYPASS_EN.
// Victim is combinational (0 cycles); updates visible the cycle after the edge; sweep takes num_sets cycles.
// While busy, updates and clear requests are dropped rather than stalled; rst overrides everything.
module plru_array #(
  parameter int s_index = 3,
  parameter int s_ways  = 2
) (
  input logic        clk,
  input logic        rst,
  plru_array_if.slave bus
);

  localparam int num_sets = 2 ** s_index;
  localparam int num_ways = 2 ** s_ways;
  localparam int tw       = num_ways - 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [s_index-1:0] sweep_cnt;
  logic               sweep_last;
  logic               sweep_we;
  logic               upd_go;
  logic [tw-1:0]      tree_q [num_sets];
  logic [tw-1:0]      upd_tree;
  logic [tw-1:0]      rd_tree;

  // Walk root to leaf; each node bit picks left (0) or right (1), root decision lands in the MSB.
  function automatic logic [s_ways-1:0] tree_walk(input logic [tw-1:0] t);
    int   node;
    logic b;
    tree_walk = '0;
    node      = 0;
    for (int l = 0; l < s_ways; l++) begin
      b = 1'b0;
      for (int n = 0; n < tw; n++) begin
        if (n == node) b = t[n];
      end
      tree_walk = (tree_walk << 1) | s_ways'(b);
      node      = 2 * node + 1 + int'(b);
    end
  endfunction

  // Point every node on the accessed way's path away from it; other nodes keep their value.
  function automatic logic [tw-1:0] tree_touch(input logic [tw-1:0] t,
                                               input logic [s_ways-1:0] way);
    int               node;
    logic             dir;
    logic [s_ways-1:0] w;
    tree_touch = t;
    node       = 0;
    w          = way;
    for (int l = 0; l < s_ways; l++) begin
      dir = w[s_ways-1];
      w   = w << 1;
      for (int n = 0; n < tw; n++) begin
        if (n == node) tree_touch[n] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
  endfunction

  assign sweep_last = (sweep_cnt == s_index'(num_sets - 1));
  assign upd_tree   = tree_touch(tree_q[bus.upd_index], bus.upd_way);

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sweep FSM next state: clear starts a sweep, last set written ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear) state_d = SWEEP;
      SWEEP:   if (sweep_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep FSM outputs; an update colliding with a clear request is dropped.
  always_comb begin
    bus.busy = (state_q == SWEEP);
    sweep_we = (state_q == SWEEP);
    upd_go   = bus.upd_en && (state_q == IDLE) && !bus.clear;
  end

  // Sweep address: held at 0 in IDLE, steps once per busy cycle and wraps.
  always_ff @(posedge clk) begin
    if (rst)                  sweep_cnt <= '0;
    else if (state_q == IDLE) sweep_cnt <= '0;
    else                      sweep_cnt <= sweep_cnt + 1'b1;
  end

  // Tree storage in flops: reset zeroes all sets, sweep zeroes one set per cycle, else record access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) tree_q[s] <= '0;
    end else if (sweep_we) begin
      tree_q[sweep_cnt] <= '0;
    end else if (upd_go) begin
      tree_q[bus.upd_index] <= upd_tree;
    end
  end

  // Victim lookup from the selected set's tree, optionally forwarding a same-cycle update.
  always_comb begin
`ifdef PLRU_BYPASS_EN
    rd_tree = tree_q[bus.rd_index];
    if (upd_go && (bus.upd_index == bus.rd_index)) rd_tree = upd_tree;
`else
    rd_tree = tree_q[bus.rd_index];
`endif
    bus.victim = tree_walk(rd_tree);
  end

endmodule
